fir_shiftreg: RTL and testbench
===============================

Name: fir_shiftreg

Overview:
- 4-tap direct-form FIR filter built on a sample shift register.
- Accepts one signed 8-bit sample per clock and four signed 8-bit coefficients, which are live inputs.
- Produces a registered, signed 11-bit filtered output.
- Sits in the datapath between the sample source (stimulus memory / ADC interface) and downstream processing.

Parameters:
- DW, 8, sample width (signed two's complement).
- CW, 8, coefficient width (signed two's complement).
- OW, 11, output width (signed two's complement).
- AW, DW+CW+2 (18 at defaults), internal accumulator width; derived localparam, not overridable.
- Tap count is fixed at 4, matching the w0..w3 ports.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- xn  input  DW  new input sample x[n], sampled every rising edge.
- w0  input  CW  coefficient applied to x[n].
- w1  input  CW  coefficient applied to x[n-1].
- w2  input  CW  coefficient applied to x[n-2].
- w3  input  CW  coefficient applied to x[n-3].
- filter_out  output  OW  registered filter result.

Behaviour:
- Reset: while rst=0, all delay registers x1..x3 = 0 and filter_out = 0, immediately (asynchronous). Release is sampled on the next rising edge; the first post-reset edge captures xn normally.
- Every rising edge with rst=1:
  - filter_out <= fmt(w0*xn + w1*x1 + w2*x2 + w3*x3), using register values before the edge.
  - Then shift: x1 <= xn, x2 <= x1, x3 <= x2.
- No sample-enable: the filter advances every clock.
- Latency: a sample presented before edge k contributes w0*sample at edge k and w3*sample at edge k+3. Impulse response length is 4 cycles.
- Arithmetic:
  - All operands are signed. Each product is a full-precision DW+CW signed value.
  - Products are sign-extended to AW and summed in AW bits; the sum cannot overflow at AW.
- Output formatting fmt(): no scaling or shift; the LSB of filter_out equals the LSB of the sum.
  - With FIR_SAT_EN: saturating narrow to OW bits (range -1024..+1023 at defaults).
  - Without FIR_SAT_EN: truncating narrow to OW bits (modular wrap).
- Coefficients are used combinationally in the cycle they are presented; they are not registered. A coefficient change affects the next edge's result only, and delayed samples are unaffected.
- Reset mid-operation: history is cleared instantly. The post-reset output reflects only samples captured after release, as if prior inputs were zero.
- No X propagation from reset: every register has a defined reset value.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: if the accumulator exceeds 2^(OW-1)-1, the output is clamped to that value. If it is below -2^(OW-1), the output is clamped to that value.
- Not defined: the output is the low OW bits of the accumulator (two's-complement wrap), and no saturation logic is synthesised.
- Both builds must pass the non-overflow tests identically.

Test Plan:
- Reset: rst=0 with xn=7 toggling, clocks running -> filter_out=0 throughout. Assert rst=0 asynchronously between edges -> filter_out goes to 0 before the next edge.
- Impulse, w0..w3=1: xn=1 for one cycle then 0 -> filter_out = 1,1,1,1 on four consecutive edges, then 0.
- Step, w0..w3=1: xn=5 held -> filter_out = 5,10,15,20, then steady 20. Then xn=-3 held -> 12,4,-4,-12, then steady -12.
- Distinct weights w0=1, w1=2, w2=-1, w3=3: xn sequence 10,0,0,0 -> 10,20,-10,30,0.
- Overflow, positive: w0..w3=-128, xn=-128 held (sum 65536) -> steady 1023 with FIR_SAT_EN, 0 without.
- Overflow, negative: w=-128, xn=127 (sum -65024) -> -1024 with FIR_SAT_EN, 512 without.
- Mid-stream reset: after a step of 5, pulse rst=0 for one cycle, then xn=1 held -> 0, then 1,2,3,4. Verifies the history was cleared.

Source files
------------

// File: rtl/fir_shiftreg.sv
// fir_shiftreg: 4-tap direct-form FIR filter on a sample shift register.
//
// Every rising edge computes w0*xn + w1*x1 + w2*x2 + w3*x3 from the current
// inputs and the delay-line contents before the edge. It registers the
// narrowed result, then shifts the delay line (x1 <= xn, x2 <= x1, x3 <= x2).
// The coefficients are live, unregistered inputs.
//
// Build option:
//   FIR_SAT_EN  defined   -> saturate the accumulator to the OW-bit signed range
//               undefined -> keep the low OW bits (two's-complement wrap)
//
// Ports:
//   clk         in   1   rising-edge clock
//   rst         in   1   asynchronous active-low reset
//   xn          in   DW  new sample x[n] (signed)
//   w0..w3      in   CW  coefficients for x[n], x[n-1], x[n-2], x[n-3] (signed)
//   filter_out  out  OW  registered filter result (signed)

module fir_shiftreg #(
    parameter int unsigned DW = 8,
    parameter int unsigned CW = 8,
    parameter int unsigned OW = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] xn,
    input  logic [CW-1:0] w0,
    input  logic [CW-1:0] w1,
    input  logic [CW-1:0] w2,
    input  logic [CW-1:0] w3,
    output logic [OW-1:0] filter_out
);

    localparam int unsigned PW  = DW + CW;  // full-precision product width
    localparam int unsigned AW  = PW + 2;   // headroom for summing four products
    localparam int unsigned EXT = AW - PW;

    logic [DW-1:0] r_x1, r_x2, r_x3;
    logic [OW-1:0] r_out;

    logic [PW-1:0] w_p0, w_p1, w_p2, w_p3;
    logic [AW-1:0] w_sum;
    logic [OW-1:0] w_fmt;

    // All operands are signed two's complement.
    assign w_p0 = PW'($signed(xn)   * $signed(w0));
    assign w_p1 = PW'($signed(r_x1) * $signed(w1));
    assign w_p2 = PW'($signed(r_x2) * $signed(w2));
    assign w_p3 = PW'($signed(r_x3) * $signed(w3));

    // Sign-extend each product to AW bits. Four products cannot overflow AW.
    assign w_sum = {{EXT{w_p0[PW-1]}}, w_p0} + {{EXT{w_p1[PW-1]}}, w_p1}
                 + {{EXT{w_p2[PW-1]}}, w_p2} + {{EXT{w_p3[PW-1]}}, w_p3};

`ifdef FIR_SAT_EN
    logic w_ovf;

    // The sum fits in OW bits only if bits AW-1 .. OW-1 are all equal.
    assign w_ovf = !((&w_sum[AW-1:OW-1]) || !(|w_sum[AW-1:OW-1]));

    always_comb begin
        w_fmt = w_sum[OW-1:0];
        if (w_ovf) begin
            // The sign of the true sum selects the clamp value.
            w_fmt = w_sum[AW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
        end
    end
`else
    logic w_unused;

    // The upper accumulator bits are dropped in the wrapping build.
    assign w_unused = ^w_sum[AW-1:OW];
    assign w_fmt    = w_sum[OW-1:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x1  <= '0;
            r_x2  <= '0;
            r_x3  <= '0;
            r_out <= '0;
        end else begin
            r_out <= w_fmt;
            r_x1  <= xn;
            r_x2  <= r_x1;
            r_x3  <= r_x2;
        end
    end

    assign filter_out = r_out;

endmodule

// File: tb/tb_fir_shiftreg.sv
// Self-checking directed testbench for fir_shiftreg.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at the
// same point, which is away from the active edge.

module tb_fir_shiftreg;

    logic        clk;
    logic        rst;
    logic [7:0]  xn;
    logic [7:0]  w0, w1, w2, w3;
    logic [10:0] filter_out;

    int checks   = 0;
    int failures = 0;

    fir_shiftreg dut (
        .clk        (clk),
        .rst        (rst),
        .xn         (xn),
        .w0         (w0),
        .w1         (w1),
        .w2         (w2),
        .w3         (w3),
        .filter_out (filter_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge. This task makes no checks.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input int a, input int b, input int c, input int d);
        w0 = 8'(a);
        w1 = 8'(b);
        w2 = 8'(c);
        w3 = 8'(d);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        set_w(1, 1, 1, 1);
        for (int i = 0; i < 4; i++) begin
            xn = (i % 2 == 0) ? 8'd7 : 8'd0;
            tick();
            checks++;
            if (filter_out !== 11'd0) begin
                failures++;
                $display("FAIL reset_hold[%0d]: got %0d expected 0", i, $signed(filter_out));
            end
        end
        rst = 1'b1;
        xn  = 8'd7;
        tick();
        checks++;
        if (filter_out !== 11'd7) begin
            failures++;
            $display("FAIL reset_first_edge: got %0d expected 7", $signed(filter_out));
        end
        tick();
        checks++;
        if (filter_out !== 11'd14) begin
            failures++;
            $display("FAIL reset_second_edge: got %0d expected 14", $signed(filter_out));
        end
        // Assert reset between edges; the output must clear without a clock edge.
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (filter_out !== 11'd0) begin
            failures++;
            $display("FAIL reset_async: got %0d expected 0", $signed(filter_out));
        end
        tick();
        checks++;
        if (filter_out !== 11'd0) begin
            failures++;
            $display("FAIL reset_async_held: got %0d expected 0", $signed(filter_out));
        end
        xn  = 8'd0;
        rst = 1'b1;
    endtask

    task automatic test_impulse();
        int exp_a[5] = '{1, 1, 1, 1, 0};
        set_w(1, 1, 1, 1);
        for (int i = 0; i < 5; i++) begin
            xn = (i == 0) ? 8'd1 : 8'd0;
            tick();
            checks++;
            if (filter_out !== 11'(exp_a[i])) begin
                failures++;
                $display("FAIL impulse[%0d]: got %0d expected %0d", i, $signed(filter_out),
                         exp_a[i]);
            end
        end
    endtask

    task automatic test_step();
        int exp_p[5] = '{5, 10, 15, 20, 20};
        int exp_n[5] = '{12, 4, -4, -12, -12};
        set_w(1, 1, 1, 1);
        xn = 8'd5;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (filter_out !== 11'(exp_p[i])) begin
                failures++;
                $display("FAIL step_pos[%0d]: got %0d expected %0d", i, $signed(filter_out),
                         exp_p[i]);
            end
        end
        xn = 8'(-3);
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (filter_out !== 11'(exp_n[i])) begin
                failures++;
                $display("FAIL step_neg[%0d]: got %0d expected %0d", i, $signed(filter_out),
                         exp_n[i]);
            end
        end
    endtask

    task automatic test_weights();
        int exp_a[5] = '{10, 20, -10, 30, 0};
        // Flush the delay line with zeros.
        set_w(0, 0, 0, 0);
        xn = 8'd0;
        for (int i = 0; i < 4; i++) tick();
        set_w(1, 2, -1, 3);
        for (int i = 0; i < 5; i++) begin
            xn = (i == 0) ? 8'd10 : 8'd0;
            tick();
            checks++;
            if (filter_out !== 11'(exp_a[i])) begin
                failures++;
                $display("FAIL weights[%0d]: got %0d expected %0d", i, $signed(filter_out),
                         exp_a[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int exp_pos;
        int exp_neg;
`ifdef FIR_SAT_EN
        exp_pos = 1023;
        exp_neg = -1024;
`else
        exp_pos = 0;    // 65536 mod 2048
        exp_neg = 512;  // -65024 mod 2048
`endif
        set_w(-128, -128, -128, -128);
        xn = 8'(-128);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (filter_out !== 11'(exp_pos)) begin
                failures++;
                $display("FAIL ovf_pos[%0d]: got %0d expected %0d", i, $signed(filter_out),
                         exp_pos);
            end
            tick();
        end
        xn = 8'd127;
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (filter_out !== 11'(exp_neg)) begin
                failures++;
                $display("FAIL ovf_neg[%0d]: got %0d expected %0d", i, $signed(filter_out),
                         exp_neg);
            end
            tick();
        end
    endtask

    task automatic test_midreset();
        int exp_a[4] = '{1, 2, 3, 4};
        set_w(1, 1, 1, 1);
        xn = 8'd5;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (filter_out !== 11'd20) begin
            failures++;
            $display("FAIL midreset_pre: got %0d expected 20", $signed(filter_out));
        end
        rst = 1'b0;
        xn  = 8'd1;
        #1;
        checks++;
        if (filter_out !== 11'd0) begin
            failures++;
            $display("FAIL midreset_clear: got %0d expected 0", $signed(filter_out));
        end
        tick();
        checks++;
        if (filter_out !== 11'd0) begin
            failures++;
            $display("FAIL midreset_hold: got %0d expected 0", $signed(filter_out));
        end
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (filter_out !== 11'(exp_a[i])) begin
                failures++;
                $display("FAIL midreset_after[%0d]: got %0d expected %0d", i,
                         $signed(filter_out), exp_a[i]);
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        xn  = 8'd0;
        set_w(0, 0, 0, 0);
        #1;
        test_reset();
        test_impulse();
        test_step();
        test_weights();
        test_overflow();
        test_midreset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
